// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with almost-full/almost-empty flags and a registered
// per-request handshake decoded from a small operation-status state machine.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        d_in,
    output logic [DATA_WIDTH-1:0]        d_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         wr_ack,
    output logic                         wr_err,
    output logic                         rd_ack,
    output logic                         rd_err,
    output logic [$clog2(DEPTH+1)-1:0]   data_count,
    output logic [2:0]                   state
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AeCnt    = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StInit   = 3'b000,
        StWrite  = 3'b001,
        StWrErr  = 3'b010,
        StNoOp   = 3'b011,
        StRead   = 3'b100,
        StRdErr  = 3'b101,
        StRdwr   = 3'b110,
        StUnused = 3'b111
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    // Marks an RD_ERR that came from a simultaneous request on an empty FIFO,
    // where the write half still succeeded.
    logic                    both_empty_q, both_empty_d;
    logic                    do_wr, do_rd;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d      = StNoOp;
        do_wr        = 1'b0;
        do_rd        = 1'b0;
        both_empty_d = 1'b0;
        // The unused code falls through to NO_OP without touching storage.
        if (state_q != StUnused) begin
            if (wr_en && rd_en) begin
                do_wr = 1'b1;
                if (cnt_q != '0) begin
                    do_rd   = 1'b1;
                    state_d = StRdwr;
                end else begin
                    state_d      = StRdErr;
                    both_empty_d = 1'b1;
                end
            end else if (wr_en) begin
                if (cnt_q < DepthCnt) begin
                    do_wr   = 1'b1;
                    state_d = StWrite;
                end else begin
                    state_d = StWrErr;
                end
            end else if (rd_en) begin
                if (cnt_q != '0) begin
                    do_rd   = 1'b1;
                    state_d = StRead;
                end else begin
                    state_d = StRdErr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            both_empty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            both_empty_q <= both_empty_d;
            if (do_wr) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (do_rd) begin
                rptr_q <= ptr_inc(rptr_q);
                dout_q <= mem[rptr_q];
            end
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem[wptr_q] <= d_in;
        end
    end

    assign d_out        = dout_q;
    assign data_count   = cnt_q;
    assign state        = state_q;
    assign full         = (cnt_q == DepthCnt);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AfCnt);
    assign almost_empty = (cnt_q <= AeCnt);

    assign wr_ack = (state_q == StWrite) || (state_q == StRdwr) ||
                    ((state_q == StRdErr) && both_empty_q);
    assign wr_err = (state_q == StWrErr);
    assign rd_ack = (state_q == StRead) || (state_q == StRdwr);
    assign rd_err = (state_q == StRdErr);

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: drives a DEPTH=8 and a DEPTH=5 instance with identical stimulus and
// checks both against queue-based reference models through per-cycle expectation queues.
module tb_fifo_param;

    typedef struct packed {
        logic [2:0]  st;
        logic        wa;
        logic        we;
        logic        ra;
        logic        re;
        logic [31:0] dout;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
    } obs_t;

    localparam int D  [2] = '{8, 5};
    localparam int AF [2] = '{6, 4};
    localparam int AE [2] = '{2, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] d_in = '0;

    logic [31:0] d_out0, d_out1;
    logic        full0, empty0, af0, ae0, wa0, we0, ra0, re0;
    logic        full1, empty1, af1, ae1, wa1, we1, ra1, re1;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  st0, st1;
    obs_t        obs0, obs1;

    obs_t        exp_q [2][$];
    logic [31:0] mq    [2][$];
    logic [31:0] mdout [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
        .d_out(d_out0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .wr_ack(wa0), .wr_err(we0), .rd_ack(ra0), .rd_err(re0),
        .data_count(cnt0), .state(st0)
    );

    fifo_param #(.DATA_WIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
        .d_out(d_out1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .wr_ack(wa1), .wr_err(we1), .rd_ack(ra1), .rd_err(re1),
        .data_count(cnt1), .state(st1)
    );

    always_comb begin
        obs0 = {st0, wa0, we0, ra0, re0, d_out0, cnt0, full0, empty0, af0, ae0};
        obs1 = {st1, wa1, we1, ra1, re1, d_out1, {1'b0, cnt1}, full1, empty1, af1, ae1};
    end

    task automatic check(input int dut, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", dut, name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the post-edge result predicted for each instance.
    task automatic step(input logic r, input logic w, input logic rd, input logic [31:0] din);
        @(negedge clk);
        reset = r;
        wr_en = w;
        rd_en = rd;
        d_in  = din;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            obs_t e;
            int   cnt;
            e = '0;
            if (r) begin
                mq[i].delete();
                mdout[i] = '0;
                e.st = 3'd0;
            end else begin
                cnt = mq[i].size();
                if (w && rd) begin
                    if (cnt > 0) begin
                        mdout[i] = mq[i].pop_front();
                        mq[i].push_back(din);
                        e.st = 3'd6;
                        e.wa = 1'b1;
                        e.ra = 1'b1;
                    end else begin
                        mq[i].push_back(din);
                        e.st = 3'd5;
                        e.wa = 1'b1;
                        e.re = 1'b1;
                    end
                end else if (w) begin
                    if (cnt < D[i]) begin
                        mq[i].push_back(din);
                        e.st = 3'd1;
                        e.wa = 1'b1;
                    end else begin
                        e.st = 3'd2;
                        e.we = 1'b1;
                    end
                end else if (rd) begin
                    if (cnt > 0) begin
                        mdout[i] = mq[i].pop_front();
                        e.st = 3'd4;
                        e.ra = 1'b1;
                    end else begin
                        e.st = 3'd5;
                        e.re = 1'b1;
                    end
                end else begin
                    e.st = 3'd3;
                end
            end
            e.dout  = mdout[i];
            e.cnt   = 4'(mq[i].size());
            e.full  = (mq[i].size() == D[i]);
            e.empty = (mq[i].size() == 0);
            e.af    = (mq[i].size() >= AF[i]);
            e.ae    = (mq[i].size() <= AE[i]);
            exp_q[i].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        for (int i = 0; i < 2; i++) begin
            if (exp_q[i].size() > 0) begin
                e = exp_q[i].pop_front();
                a = (i == 0) ? obs0 : obs1;
                check(i, "state",        32'(a.st),    32'(e.st));
                check(i, "wr_ack",       32'(a.wa),    32'(e.wa));
                check(i, "wr_err",       32'(a.we),    32'(e.we));
                check(i, "rd_ack",       32'(a.ra),    32'(e.ra));
                check(i, "rd_err",       32'(a.re),    32'(e.re));
                check(i, "d_out",        a.dout,       e.dout);
                check(i, "data_count",   32'(a.cnt),   32'(e.cnt));
                check(i, "full",         32'(a.full),  32'(e.full));
                check(i, "empty",        32'(a.empty), 32'(e.empty));
                check(i, "almost_full",  32'(a.af),    32'(e.af));
                check(i, "almost_empty", 32'(a.ae),    32'(e.ae));
            end
        end
    end

    initial begin
        int pct;
        // Reset wins over a simultaneous write, then idle.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Fill past full, then drain past empty.
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
        repeat (9) step(1'b0, 1'b0, 1'b1, 32'h0);
        // Simultaneous read+write on a full FIFO, then drain to show wrap-around.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
        step(1'b0, 1'b1, 1'b1, 32'hAA);
        repeat (9) step(1'b0, 1'b0, 1'b1, 32'h0);
        // Simultaneous request on an empty FIFO: write lands, read fails.
        step(1'b0, 1'b1, 1'b1, 32'h55);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        // Mid-stream reset with a write pending, then write/read pairs across the wrap.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, 32'(8'hC0 + i));
        step(1'b1, 1'b1, 1'b0, 32'hEE);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, $urandom);
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        // Random traffic, alternating write-heavy and read-heavy phases, rare resets.
        pct = 70;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) pct = 100 - pct;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < pct),
                 ($urandom_range(0, 99) < 100 - pct + 10), $urandom);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) check(i, "drained", 32'(exp_q[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
